// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared VGA timing constants and helpers
package vga_timing_pkg;

   // 640x480@60 from a 50 MHz system clock (25 MHz pixel rate)
   localparam int VGA640_PIX_DIV = 2;
   localparam int VGA640_H_VIS   = 640;
   localparam int VGA640_H_FP    = 16;
   localparam int VGA640_H_SYNC  = 96;
   localparam int VGA640_H_BP    = 48;
   localparam int VGA640_V_VIS   = 480;
   localparam int VGA640_V_FP    = 10;
   localparam int VGA640_V_SYNC  = 2;
   localparam int VGA640_V_BP    = 33;

   // 800x600@72 from a 50 MHz system clock (50 MHz pixel rate)
   localparam int SVGA800_PIX_DIV = 1;
   localparam int SVGA800_H_VIS   = 800;
   localparam int SVGA800_H_FP    = 56;
   localparam int SVGA800_H_SYNC  = 120;
   localparam int SVGA800_H_BP    = 64;
   localparam int SVGA800_V_VIS   = 600;
   localparam int SVGA800_V_FP    = 37;
   localparam int SVGA800_V_SYNC  = 6;
   localparam int SVGA800_V_BP    = 23;

   localparam logic SYNC_ACTIVE_LOW  = 1'b0;
   localparam logic SYNC_ACTIVE_HIGH = 1'b1;

   function automatic int timing_total(input int vis, input int fp, input int sync, input int bp);
      return vis + fp + sync + bp;
   endfunction

endpackage

// File: rtl/vga_pix_div.sv
// rtl/vga_pix_div.sv - system clock divider producing the pixel tick
module vga_pix_div #(
   parameter int PIX_DIV = 2
) (
   input  logic clock,
   input  logic reset,
   output logic tick
);

   // A one-bit counter pinned at zero keeps PIX_DIV=1 on the same path with tick always high.
   localparam int CW = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [CW-1:0] LAST = CW'(PIX_DIV - 1);

   logic [CW-1:0] div_cnt;

   always_ff @(posedge clock) begin
      if (reset) begin
         div_cnt <= '0;
      end else if (div_cnt == LAST) begin
         div_cnt <= '0;
      end else begin
         div_cnt <= div_cnt + CW'(1);
      end
   end

   assign tick = (div_cnt == LAST);

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA raster counters, syncs and line/frame strobes
module vga_timing_gen
   import vga_timing_pkg::*;
#(
   parameter int   PIX_DIV  = VGA640_PIX_DIV,
   parameter int   H_VIS    = VGA640_H_VIS,
   parameter int   H_FP     = VGA640_H_FP,
   parameter int   H_SYNC   = VGA640_H_SYNC,
   parameter int   H_BP     = VGA640_H_BP,
   parameter int   V_VIS    = VGA640_V_VIS,
   parameter int   V_FP     = VGA640_V_FP,
   parameter int   V_SYNC   = VGA640_V_SYNC,
   parameter int   V_BP     = VGA640_V_BP,
   parameter int   H_BITS   = 10,
   parameter int   V_BITS   = 10,
   parameter logic SYNC_POL = SYNC_ACTIVE_LOW
) (
   input  logic              clock,
   input  logic              reset,
   output logic              pixel_ce,
   output logic [H_BITS-1:0] hcount,
   output logic [V_BITS-1:0] vcount,
   output logic              active,
   output logic              hsync,
   output logic              vsync,
   output logic              line_start,
   output logic              frame_start
);

   localparam int H_TOTAL = timing_total(H_VIS, H_FP, H_SYNC, H_BP);
   localparam int V_TOTAL = timing_total(V_VIS, V_FP, V_SYNC, V_BP);
   localparam logic [H_BITS-1:0] H_LAST = H_BITS'(H_TOTAL - 1);
   localparam logic [V_BITS-1:0] V_LAST = V_BITS'(V_TOTAL - 1);

   logic              tick;
   logic [H_BITS-1:0] h_next;
   logic [V_BITS-1:0] v_next;
   logic              active_next;
   logic              hsync_next;
   logic              vsync_next;
   int                h_ext;
   int                v_ext;

   vga_pix_div #(
      .PIX_DIV(PIX_DIV)
   ) u_pix_div (
      .clock(clock),
      .reset(reset),
      .tick (tick)
   );

   // Decode from the upcoming coordinate so every registered output describes the same pixel.
   always_comb begin
      h_next = hcount + H_BITS'(1);
      v_next = vcount;
      if (hcount == H_LAST) begin
         h_next = '0;
         v_next = (vcount == V_LAST) ? '0 : vcount + V_BITS'(1);
      end
      h_ext       = int'(h_next);
      v_ext       = int'(v_next);
      active_next = (h_ext < H_VIS) && (v_ext < V_VIS);
      hsync_next  = ((h_ext >= H_VIS + H_FP) && (h_ext < H_VIS + H_FP + H_SYNC)) ? SYNC_POL : ~SYNC_POL;
      vsync_next  = ((v_ext >= V_VIS + V_FP) && (v_ext < V_VIS + V_FP + V_SYNC)) ? SYNC_POL : ~SYNC_POL;
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         pixel_ce    <= 1'b0;
         hcount      <= H_LAST;
         vcount      <= V_LAST;
         active      <= 1'b0;
         hsync       <= ~SYNC_POL;
         vsync       <= ~SYNC_POL;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end else if (tick) begin
         pixel_ce    <= 1'b1;
         hcount      <= h_next;
         vcount      <= v_next;
         active      <= active_next;
         hsync       <= hsync_next;
         vsync       <= vsync_next;
         line_start  <= (h_next == '0);
         frame_start <= (h_next == '0) && (v_next == '0);
      end else begin
         pixel_ce    <= 1'b0;
         line_start  <= 1'b0;
         frame_start <= 1'b0;
      end
   end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - directed checks for the VGA timing generator
module tb_vga_timing_gen;

   logic clock = 1'b0;
   logic reset = 1'b1;
   always #5 clock = ~clock;

   // A: defaults 640x480, PIX_DIV=2, active-low syncs
   logic       a_pce, a_act, a_hs, a_vs, a_ls, a_fs;
   logic [9:0] a_h, a_v;
   // B: PIX_DIV=1, active-high syncs, H 4/1/2/1, V 3/1/1/1
   logic       b_pce, b_act, b_hs, b_vs, b_ls, b_fs;
   logic [2:0] b_h, b_v;
   // C: PIX_DIV=3, active-low syncs, H 10/2/3/1, V 5/1/2/2
   logic       c_pce, c_act, c_hs, c_vs, c_ls, c_fs;
   logic [3:0] c_h, c_v;

   vga_timing_gen u_a (
      .clock(clock), .reset(reset), .pixel_ce(a_pce), .hcount(a_h), .vcount(a_v),
      .active(a_act), .hsync(a_hs), .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs)
   );

   vga_timing_gen #(
      .PIX_DIV(1), .H_VIS(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
      .V_VIS(3), .V_FP(1), .V_SYNC(1), .V_BP(1), .H_BITS(3), .V_BITS(3), .SYNC_POL(1'b1)
   ) u_b (
      .clock(clock), .reset(reset), .pixel_ce(b_pce), .hcount(b_h), .vcount(b_v),
      .active(b_act), .hsync(b_hs), .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs)
   );

   vga_timing_gen #(
      .PIX_DIV(3), .H_VIS(10), .H_FP(2), .H_SYNC(3), .H_BP(1),
      .V_VIS(5), .V_FP(1), .V_SYNC(2), .V_BP(2), .H_BITS(4), .V_BITS(4), .SYNC_POL(1'b0)
   ) u_c (
      .clock(clock), .reset(reset), .pixel_ce(c_pce), .hcount(c_h), .vcount(c_v),
      .active(c_act), .hsync(c_hs), .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs)
   );

   typedef struct {
      int   edge_n;
      logic pce;
      int   h;
      int   v;
      logic act, hs, vs, ls, fs;
   } vec_t;

   vec_t tbl [14];
   int   vectors = 0;
   int   miscompares = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   function automatic logic [31:0] pack_a();
      return {6'b0, a_pce, a_h, a_v, a_act, a_hs, a_vs, a_ls, a_fs};
   endfunction

   function automatic logic [31:0] pack_exp(input vec_t e);
      return {6'b0, e.pce, 10'(e.h), 10'(e.v), e.act, e.hs, e.vs, e.ls, e.fs};
   endfunction

   initial begin
      int   cur;
      int   n_pce, n_hs_pix, n_hs_clk, n_act, n_ls;
      logic found;
      int   c_first_pce, c_fs_n, c_act_f0, c_vs_f0, c_vs_first, c_hs_l0;
      int   c_fs_edge [3];
      logic [31:0] c_vs_pos;
      int   b_fs_n;
      vec_t e;

      //             edge  pce   h    v   act   hs    vs    ls    fs
      tbl[0]  = '{    0, 1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{    1, 1'b0, 799, 524, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{    2, 1'b1,   0,   0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
      tbl[3]  = '{    3, 1'b0,   0,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{    4, 1'b1,   1,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{ 1280, 1'b1, 639,   0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{ 1282, 1'b1, 640,   0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{ 1312, 1'b1, 655,   0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{ 1314, 1'b1, 656,   0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{ 1315, 1'b0, 656,   0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{ 1504, 1'b1, 751,   0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
      tbl[11] = '{ 1506, 1'b1, 752,   0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[12] = '{ 1600, 1'b1, 799,   0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      tbl[13] = '{ 1602, 1'b1,   0,   1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

      reset = 1'b1;
      repeat (3) step();
      check("a_reset_state", pack_a(), pack_exp(tbl[0]));
      reset = 1'b0;
      cur = 0;
      for (int i = 1; i < 14; i++) begin
         while (cur < tbl[i].edge_n) begin
            step();
            cur++;
         end
         check($sformatf("a_vec_edge%0d", tbl[i].edge_n), pack_a(), pack_exp(tbl[i]));
      end

      // one full line of A: line 1 pixels 1..799 plus pixel 0 of line 2
      n_pce = 0; n_hs_pix = 0; n_hs_clk = 0; n_act = 0; n_ls = 0;
      for (int k = 0; k < 1600; k++) begin
         step();
         if (!a_hs) n_hs_clk++;
         if (a_pce) begin
            n_pce++;
            if (!a_hs) n_hs_pix++;
            if (a_act) n_act++;
            if (a_ls) n_ls++;
         end
      end
      check("a_line_pce", n_pce, 800);
      check("a_line_hsync_pix", n_hs_pix, 96);
      check("a_line_hsync_clk", n_hs_clk, 192);
      check("a_line_active", n_act, 640);
      check("a_line_start", n_ls, 1);

      // reset in the middle of a line
      found = 1'b0;
      for (int k = 0; k < 2000 && !found; k++) begin
         if (a_pce && a_h == 10'd300) found = 1'b1;
         else step();
      end
      check("a_find_h300", found, 1);
      reset = 1'b1;
      step();
      check("a_midline_reset", pack_a(), pack_exp(tbl[0]));
      reset = 1'b0;

      c_first_pce = -1; c_fs_n = 0; c_act_f0 = 0; c_vs_f0 = 0; c_vs_first = -1; c_hs_l0 = 0;
      c_vs_pos = '0; b_fs_n = 0;
      for (int k = 1; k <= 1000; k++) begin
         step();
         if (k == 1) check("a_post_reset_edge1_fs", {a_pce, a_fs}, 2'b00);
         if (k == 2) check("a_post_reset_edge2_fs", {a_pce, a_fs, a_h, a_v}, {2'b11, 20'd0});
         if (k <= 100) begin
            int idx, h, v;
            idx = k - 1;
            h = idx % 8;
            v = (idx / 8) % 6;
            e = '{k, 1'b1, h, v, (h < 4 && v < 3), (h == 5 || h == 6), (v == 4), (h == 0), (h == 0 && v == 0)};
            check($sformatf("b_edge%0d", k), {20'b0, b_pce, b_h, b_v, b_act, b_hs, b_vs, b_ls, b_fs},
                  {20'b0, e.pce, 3'(e.h), 3'(e.v), e.act, e.hs, e.vs, e.ls, e.fs});
            if (b_fs) b_fs_n++;
         end
         if (c_pce) begin
            if (c_first_pce < 0) c_first_pce = k;
            if (c_fs) begin
               if (c_fs_n < 3) c_fs_edge[c_fs_n] = k;
               c_fs_n++;
            end
            if (k <= 480) begin
               if (c_act) c_act_f0++;
               if (!c_vs) c_vs_f0++;
               if (!c_hs && c_v == 4'd0) c_hs_l0++;
               if (!c_vs && c_vs_first < 0) begin
                  c_vs_first = k;
                  c_vs_pos = {24'b0, c_h, c_v};
               end
            end
            if (k == 480) check("c_last_pixel", {c_h, c_v}, {4'd15, 4'd9});
            if (k == 483) check("c_wrap_pixel", {c_h, c_v, c_fs}, {8'd0, 1'b1});
         end
      end
      check("b_frame_starts", b_fs_n, 3);
      check("c_first_pce_edge", c_first_pce, 3);
      check("c_frame_start_count", c_fs_n, 3);
      if (c_fs_n >= 3) begin
         check("c_frame_start0", c_fs_edge[0], 3);
         check("c_frame_period", c_fs_edge[1] - c_fs_edge[0], 480);
         check("c_frame_start2", c_fs_edge[2], 963);
      end
      check("c_active_pixels", c_act_f0, 50);
      check("c_vsync_pixels", c_vs_f0, 32);
      check("c_vsync_first_edge", c_vs_first, 291);
      check("c_vsync_first_pos", c_vs_pos, {24'b0, 4'd0, 4'd6});
      check("c_hsync_line0", c_hs_l0, 3);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
